// File: rtl/i2c_reg_slave_engine.sv
// I2C slave byte engine feeding a register interface (addr/dataIn/writeEn, registered dataOut readback).
// Optional SCL-low stall abort enabled by defining I2C_SLAVE_TIMEOUT_EN.
module i2c_reg_slave_engine #(
  parameter logic [6:0]  DEVICE_ADDR    = 7'h3C,
  parameter int unsigned DEGLITCH_LEN   = 3,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sdaOut,
  output logic [7:0] regAddr,
  output logic [7:0] dataToRegIf,
  output logic       writeEn,
  input  logic [7:0] dataFromRegIf,
  output logic       busy
);

  localparam int unsigned LINE_SCL = 0;
  localparam int unsigned LINE_SDA = 1;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR,
    RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] meta_q, sync_q, filt_q, filt_prev_q;
  logic [2:0] glitch_cnt_q [2];

  // Two-flop synchroniser then a run-length deglitch filter on both lines
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q          <= '1;
      sync_q          <= '1;
      filt_q          <= '1;
      filt_prev_q     <= '1;
      glitch_cnt_q[0] <= '0;
      glitch_cnt_q[1] <= '0;
    end else begin
      meta_q      <= {sdaIn, sclIn};
      sync_q      <= meta_q;
      filt_prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          glitch_cnt_q[i] <= '0;
        end else if (glitch_cnt_q[i] == 3'(DEGLITCH_LEN - 1)) begin
          filt_q[i]       <= sync_q[i];
          glitch_cnt_q[i] <= '0;
        end else begin
          glitch_cnt_q[i] <= glitch_cnt_q[i] + 3'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_cond, stop_cond;
  assign scl_f      = filt_q[LINE_SCL];
  assign sda_f      = filt_q[LINE_SDA];
  assign scl_rise   = scl_f & ~filt_prev_q[LINE_SCL];
  assign scl_fall   = ~scl_f & filt_prev_q[LINE_SCL];
  assign start_cond = scl_f & filt_prev_q[LINE_SCL] & filt_prev_q[LINE_SDA] & ~sda_f;
  assign stop_cond  = scl_f & filt_prev_q[LINE_SCL] & ~filt_prev_q[LINE_SDA] & sda_f;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       sda_out_q, sda_out_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] data_q, data_d;
  logic       wr_en_q, wr_en_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda_f};

`ifdef I2C_SLAVE_TIMEOUT_EN
  logic [19:0] to_cnt_q, to_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      sda_out_q  <= 1'b1;
      reg_addr_q <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef I2C_SLAVE_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      sda_out_q  <= sda_out_d;
      reg_addr_q <= reg_addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
`ifdef I2C_SLAVE_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_out_d  = sda_out_q;
    reg_addr_d = reg_addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    busy_d     = busy_q;

    if (start_cond) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else if (stop_cond) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shift_q[6:0] == DEVICE_ADDR) begin
              rw_d    = sda_f;
              busy_d  = 1'b1;
              state_d = ACK_DEV;
            end else begin
              busy_d  = 1'b0;
              state_d = WAIT_STOP;
            end
          end
        end
        // ACK phases: pull low on the first SCL fall, release on the second
        ACK_DEV: if (scl_fall) begin
          sda_out_d = ~sda_out_q;
          if (!sda_out_q) state_d = rw_q ? RD_LOAD : REG_ADDR;
        end
        REG_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            reg_addr_d = byte_in;
            state_d    = ACK_REG;
          end
        end
        ACK_REG: if (scl_fall) begin
          sda_out_d = ~sda_out_q;
          if (!sda_out_q) state_d = WR_DATA;
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            data_d  = byte_in;
            wr_en_d = 1'b1;
            state_d = ACK_WR;
          end
        end
        ACK_WR: if (scl_fall) begin
          sda_out_d = ~sda_out_q;
          if (!sda_out_q) begin
            reg_addr_d = reg_addr_q + 8'd1;
            state_d    = WR_DATA;
          end
        end
        // Wait out the interface latency, latch, then drive the MSB only while SCL is low
        RD_LOAD: begin
          case (bit_cnt_q)
            3'd0:    bit_cnt_d = 3'd1;
            3'd1: begin
              shift_d   = dataFromRegIf;
              bit_cnt_d = 3'd2;
            end
            default: if (!scl_f) begin
              sda_out_d = shift_q[7];
              bit_cnt_d = '0;
              state_d   = RD_DATA;
            end
          endcase
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_out_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = RD_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_out_d = shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // Address advances past every transmitted byte, ACKed or not
        RD_ACK: if (scl_rise) begin
          reg_addr_d = reg_addr_q + 8'd1;
          bit_cnt_d  = '0;
          if (!sda_f) begin
            state_d = RD_LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end

`ifdef I2C_SLAVE_TIMEOUT_EN
    to_cnt_d = (busy_q && !scl_f) ? to_cnt_q + 20'd1 : '0;
    if (busy_q && !scl_f && (to_cnt_q == TIMEOUT_CYCLES - 20'd1)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
      wr_en_d   = 1'b0;
      to_cnt_d  = '0;
    end
`endif
  end

  assign sdaOut      = sda_out_q;
  assign regAddr     = reg_addr_q;
  assign dataToRegIf = data_q;
  assign writeEn     = wr_en_q;
  assign busy        = busy_q;

endmodule

// File: doc/i2c_reg_slave_engine.md
Name: i2c_reg_slave_engine

Overview:
- I2C slave serial engine directly upstream of the register interface block (OSD RAM, OSD enable, highlight line, reconf, controller/debug readback).
- Decodes the bus, matches the device address, and drives the register interface addr / dataIn / writeEn with one-cycle write strobes.
- Serialises the interface's registered dataOut back to the master, with register-address auto-increment.

Parameters:
- DEVICE_ADDR, 7'h3C, 7-bit I2C slave address matched in the address byte.
- DEGLITCH_LEN, 3, consecutive identical clk samples required before a filtered SCL/SDA level changes (1..7).
- TIMEOUT_CYCLES, 20'd1000000, clk cycles of SCL held low while busy before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- sclIn  in  1  raw SCL pin level (asynchronous).
- sdaIn  in  1  raw SDA pin level (asynchronous).
- sdaOut  out  1  SDA drive: 0 = pull low, 1 = release.
- regAddr  out  8  register address to the register interface (addr).
- dataToRegIf  out  8  write byte to the register interface (dataIn).
- writeEn  out  1  one-cycle write strobe.
- dataFromRegIf  in  8  register interface dataOut (1-cycle registered latency from regAddr).
- busy  out  1  high from a matched START until STOP, NACK-end or abort.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low (reset_n, sampled on posedge clk only).
- Reset values: sdaOut=1, regAddr=0, dataToRegIf=0, writeEn=0, busy=0, state IDLE. The filters preset to 1, so no false START occurs after reset.
- Input path: 2-FF synchroniser per line, then a deglitch counter. The filtered level updates only after DEGLITCH_LEN equal samples.
- Edge detection on filtered lines:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Bits are sampled on SCL rise. sdaOut changes only on the clk following SCL fall.
- States: IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state (repeated START included) -> DEV_ADDR. Bit counter clears, sdaOut=1, regAddr is retained.
- STOP from any state -> IDLE. sdaOut=1, busy=0, regAddr retained.
- DEV_ADDR: shift 8 bits MSB first.
  - addr[7:1]==DEVICE_ADDR -> ACK_DEV, busy=1.
  - Mismatch -> WAIT_STOP (never drive SDA; leave only on START or STOP).
- ACK_DEV: drive 0 from SCL fall after bit 8 until the next SCL fall, then:
  - R/W=0 -> REG_ADDR.
  - R/W=1 -> RD_LOAD.
- REG_ADDR: 8 bits; regAddr loads on the 8th SCL rise. ACK_REG acks, then -> WR_DATA.
- WR_DATA: on the 8th SCL rise, dataToRegIf loads and writeEn=1 on the next clk for exactly one cycle. ACK_WR acks. regAddr increments on the SCL fall ending ACK (8'hFF wraps to 8'h00), then -> WR_DATA.
- RD_LOAD: one clk after entry (covers the 1-cycle interface latency), latch dataFromRegIf into the shift register -> RD_DATA, driving the MSB.
- RD_DATA: shift on each SCL fall; after 8 bits release SDA -> RD_ACK.
- RD_ACK: sample on SCL rise.
  - 0 (ACK): regAddr+1 (wrapping) -> RD_LOAD.
  - 1 (NACK): -> WAIT_STOP.
- Write after repeated START: address retained, so a read continues from the last written address+1 or the REG_ADDR value.
- writeEn is never asserted in read states or after a mismatch. STOP during a data byte discards the partial byte (no writeEn).
- Reset asserted mid-transfer: all outputs return to reset values on the next clk; SDA is released immediately.

Optional Feature:
- Macro I2C_SLAVE_TIMEOUT_EN.
- Defined: a 20-bit counter runs while busy=1 and filtered SCL=0, and clears on SCL high. Reaching TIMEOUT_CYCLES forces IDLE, sdaOut=1, busy=0, with no writeEn.
- Undefined: no counter; a stalled master holds the engine in its state indefinitely.

Test Plan:
- Write START, 0x78, 0x81, 0x01, STOP -> three ACKs; regAddr=0x81 at strobe; one writeEn pulse with dataToRegIf=0x01; regAddr=0x82 after; busy low after STOP.
- Burst write START, 0x78, 0x7E, 0xAA, 0xBB, 0xCC, STOP -> writeEn pulses at regAddr 0x7E, 0x7F, 0x80 with data AA, BB, CC.
- Read START, 0x78, 0x90, repeated START, 0x79, read 2 bytes (ACK then NACK), STOP, with model dataOut=regAddr^0x5A -> bytes 0xCA, 0xCB; regAddr=0x92; sdaOut=1 after NACK.
- Mismatch START, 0x50, 0x81, 0x01, STOP -> sdaOut stays 1 throughout; writeEn never asserted; busy=0.
- Wrap: write to reg 0xFF then a second byte -> strobes at 0xFF then 0x00. Reset_n low mid-byte -> sdaOut=1, writeEn=0 on the next clk.
- Glitch: 2-cycle SDA low pulse while SCL high, with DEGLITCH_LEN=3 -> no START detected. With I2C_SLAVE_TIMEOUT_EN and TIMEOUT_CYCLES=100, SCL held low 100 cycles mid-byte -> busy=0, sdaOut=1.
